video_timing_pipe: RTL and testbench

//  Parametrised successor to the fixed 720p video signal generator. Produces raster counters, syncs,

---
 rtl/video_timing_pipe_if.sv | 26 ++
 rtl/video_timing_pipe.sv | 139 +++++++++++++
 tb/tb_video_timing_pipe.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/video_timing_pipe_if.sv
// Bundle of raster outputs from video_timing_pipe, used to carry timing to the
// renderer and to the TMDS encoder path.
interface video_timing_pipe_if #(
    parameter int HW = 11,
    parameter int VW = 10,
    parameter int FW = 6
);
    logic [HW-1:0] hcount;
    logic [VW-1:0] vcount;
    logic          hs;
    logic          vs;
    logic          ad;
    logic          nf;
    logic [FW-1:0] fc;
    logic          hs_d;
    logic          vs_d;
    logic          ad_d;

    modport master (
        output hcount, vcount, hs, vs, ad, nf, fc, hs_d, vs_d, ad_d
    );

    modport slave (
        input hcount, vcount, hs, vs, ad, nf, fc, hs_d, vs_d, ad_d
    );
endinterface

// File: rtl/video_timing_pipe.sv
// Parametrised progressive video timing generator with programmable sync polarity
// and a fixed-depth delay line for the hs/vs/ad copies feeding the TMDS path.
module video_timing_pipe #(
    parameter int ACTIVE_H   = 1280,
    parameter int FP_H       = 110,
    parameter int SYNC_H     = 40,
    parameter int BP_H       = 220,
    parameter int ACTIVE_V   = 720,
    parameter int FP_V       = 5,
    parameter int SYNC_V     = 5,
    parameter int BP_V       = 20,
    parameter int FPS        = 60,
    parameter bit HS_POL     = 1'b1,
    parameter bit VS_POL     = 1'b1,
    parameter int PIPE_DELAY = 4,
    localparam int H_TOTAL   = ACTIVE_H + FP_H + SYNC_H + BP_H,
    localparam int V_TOTAL   = ACTIVE_V + FP_V + SYNC_V + BP_V,
    localparam int HW        = $clog2(H_TOTAL),
    localparam int VW        = $clog2(V_TOTAL),
    localparam int FW        = (FPS > 1) ? $clog2(FPS) : 1
) (
    input  logic          clk_pixel_in,
    input  logic          rst_in,
    output logic [HW-1:0] hcount_out,
    output logic [VW-1:0] vcount_out,
    output logic          hs_out,
    output logic          vs_out,
    output logic          ad_out,
    output logic          nf_out,
    output logic [FW-1:0] fc_out,
    output logic          hs_d_out,
    output logic          vs_d_out,
    output logic          ad_d_out
);
    generate
        if (ACTIVE_H < 1 || FP_H < 1 || SYNC_H < 1 || BP_H < 1 ||
            ACTIVE_V < 1 || FP_V < 1 || SYNC_V < 1 || BP_V < 1 ||
            FPS < 1 || PIPE_DELAY < 0 || PIPE_DELAY > 15) begin : g_bad_param
            $error("video_timing_pipe: illegal timing parameters");
        end
    endgenerate

    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT    = HW'(ACTIVE_H);
    localparam logic [VW-1:0] V_ACT    = VW'(ACTIVE_V);
    localparam logic [HW-1:0] HS_START = HW'(ACTIVE_H + FP_H);
    localparam logic [HW-1:0] HS_STOP  = HW'(ACTIVE_H + FP_H + SYNC_H);
    localparam logic [VW-1:0] VS_START = VW'(ACTIVE_V + FP_V);
    localparam logic [VW-1:0] VS_STOP  = VW'(ACTIVE_V + FP_V + SYNC_V);
    localparam logic [FW-1:0] FC_LAST  = FW'(FPS - 1);
    localparam logic [2:0]    TAP_IDLE = {1'b0, ~VS_POL, ~HS_POL};

    // r_run holds the raster at (0,0) for the first edge after reset release,
    // so pixel (0,0) is presented as active exactly once.
    logic          r_run;
    logic [HW-1:0] r_h;
    logic [VW-1:0] r_v;
    logic [FW-1:0] r_fc;
    logic          r_hs, r_vs, r_ad, r_nf;

    logic [HW-1:0] w_h_next;
    logic [VW-1:0] w_v_next;
    logic [FW-1:0] w_fc_next;
    logic          w_hs_next, w_vs_next, w_ad_next, w_nf_next;

    always_comb begin
        w_h_next = '0;
        w_v_next = '0;
        if (r_run) begin
            if (r_h == H_LAST) begin
                w_h_next = '0;
                w_v_next = (r_v == V_LAST) ? '0 : r_v + 1'b1;
            end else begin
                w_h_next = r_h + 1'b1;
                w_v_next = r_v;
            end
        end
        w_ad_next = (w_h_next < H_ACT) && (w_v_next < V_ACT);
        w_hs_next = (w_h_next >= HS_START && w_h_next < HS_STOP) ? HS_POL : ~HS_POL;
        w_vs_next = (w_v_next >= VS_START && w_v_next < VS_STOP) ? VS_POL : ~VS_POL;
        w_nf_next = (w_h_next == H_ACT) && (w_v_next == V_ACT);
        w_fc_next = r_fc;
        if (w_nf_next) begin
            w_fc_next = (r_fc == FC_LAST) ? '0 : r_fc + 1'b1;
        end
    end

    always_ff @(posedge clk_pixel_in) begin
        if (rst_in) begin
            r_run <= 1'b0;
            r_h   <= '0;
            r_v   <= '0;
            r_fc  <= '0;
            r_hs  <= ~HS_POL;
            r_vs  <= ~VS_POL;
            r_ad  <= 1'b0;
            r_nf  <= 1'b0;
        end else begin
            r_run <= 1'b1;
            r_h   <= w_h_next;
            r_v   <= w_v_next;
            r_fc  <= w_fc_next;
            r_hs  <= w_hs_next;
            r_vs  <= w_vs_next;
            r_ad  <= w_ad_next;
            r_nf  <= w_nf_next;
        end
    end

    assign hcount_out = r_h;
    assign vcount_out = r_v;
    assign fc_out     = r_fc;
    assign hs_out     = r_hs;
    assign vs_out     = r_vs;
    assign ad_out     = r_ad;
    assign nf_out     = r_nf;

    // Tap 0 is the live {ad,vs,hs}; tap N is that value N cycles ago.
    logic [PIPE_DELAY:0][2:0] w_tap;
    assign w_tap[0] = {r_ad, r_vs, r_hs};

    genvar gi;
    generate
        for (gi = 0; gi < PIPE_DELAY; gi++) begin : g_stage
            logic [2:0] r_q;
            always_ff @(posedge clk_pixel_in) begin
                if (rst_in) begin
                    r_q <= TAP_IDLE;
                end else begin
                    r_q <= w_tap[gi];
                end
            end
            assign w_tap[gi+1] = r_q;
        end
    endgenerate

    assign {ad_d_out, vs_d_out, hs_d_out} = w_tap[PIPE_DELAY];
endmodule

// File: tb/tb_video_timing_pipe.sv
// Directed checks of video_timing_pipe in three configurations: default 720p
// timing (line level), a tiny 8x6 raster, and a 24x15 raster with mid-frame reset.
module tb_video_timing_pipe;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_d, rst_s, rst_m;
    int n_run  = 0;
    int n_fail = 0;

    video_timing_pipe_if #(.HW(11), .VW(10), .FW(6)) if_d ();
    video_timing_pipe_if #(.HW(3),  .VW(3),  .FW(2)) if_s ();
    video_timing_pipe_if #(.HW(5),  .VW(4),  .FW(5)) if_m ();

    video_timing_pipe dut_d (
        .clk_pixel_in(clk), .rst_in(rst_d),
        .hcount_out(if_d.hcount), .vcount_out(if_d.vcount),
        .hs_out(if_d.hs), .vs_out(if_d.vs), .ad_out(if_d.ad), .nf_out(if_d.nf),
        .fc_out(if_d.fc), .hs_d_out(if_d.hs_d), .vs_d_out(if_d.vs_d), .ad_d_out(if_d.ad_d)
    );

    video_timing_pipe #(
        .ACTIVE_H(4), .FP_H(1), .SYNC_H(2), .BP_H(1),
        .ACTIVE_V(3), .FP_V(1), .SYNC_V(1), .BP_V(1),
        .FPS(3), .HS_POL(1'b0), .VS_POL(1'b0), .PIPE_DELAY(0)
    ) dut_s (
        .clk_pixel_in(clk), .rst_in(rst_s),
        .hcount_out(if_s.hcount), .vcount_out(if_s.vcount),
        .hs_out(if_s.hs), .vs_out(if_s.vs), .ad_out(if_s.ad), .nf_out(if_s.nf),
        .fc_out(if_s.fc), .hs_d_out(if_s.hs_d), .vs_d_out(if_s.vs_d), .ad_d_out(if_s.ad_d)
    );

    video_timing_pipe #(
        .ACTIVE_H(16), .FP_H(2), .SYNC_H(3), .BP_H(3),
        .ACTIVE_V(10), .FP_V(1), .SYNC_V(2), .BP_V(2),
        .FPS(20), .PIPE_DELAY(3)
    ) dut_m (
        .clk_pixel_in(clk), .rst_in(rst_m),
        .hcount_out(if_m.hcount), .vcount_out(if_m.vcount),
        .hs_out(if_m.hs), .vs_out(if_m.vs), .ad_out(if_m.ad), .nf_out(if_m.nf),
        .fc_out(if_m.fc), .hs_d_out(if_m.hs_d), .vs_d_out(if_m.vs_d), .ad_d_out(if_m.ad_d)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int ad_cnt;
        int hd, vv, off, fr, fce;

        rst_d = 1'b1;
        rst_s = 1'b1;
        rst_m = 1'b1;
        tick();
        tick();

        // Reset state of all three instances
        check("d_rst_h",  if_d.hcount, 0);
        check("d_rst_v",  if_d.vcount, 0);
        check("d_rst_fc", if_d.fc, 0);
        check("d_rst_nf", if_d.nf, 0);
        check("d_rst_ad", if_d.ad, 0);
        check("d_rst_hs", if_d.hs, 0);
        check("d_rst_vs", if_d.vs, 0);
        check("d_rst_add", if_d.ad_d, 0);
        check("d_rst_hsd", if_d.hs_d, 0);
        check("d_rst_vsd", if_d.vs_d, 0);
        check("s_rst_hs", if_s.hs, 1);
        check("s_rst_vs", if_s.vs, 1);
        check("s_rst_ad", if_s.ad, 0);
        check("s_rst_hsd", if_s.hs_d, 1);
        check("s_rst_vsd", if_s.vs_d, 1);
        check("m_rst_h",  if_m.hcount, 0);
        check("m_rst_ad", if_m.ad, 0);

        // Default timing: first line and into the second
        rst_d = 1'b0;
        ad_cnt = 0;
        for (int k = 0; k <= 1660; k++) begin
            tick();
            hd = k % 1650;
            check("d_h", if_d.hcount, hd);
            check("d_v", if_d.vcount, k / 1650);
            check("d_ad", if_d.ad, (hd < 1280) ? 1 : 0);
            check("d_hs", if_d.hs, (hd >= 1390 && hd <= 1429) ? 1 : 0);
            check("d_vs", if_d.vs, 0);
            check("d_nf", if_d.nf, 0);
            check("d_fc", if_d.fc, 0);
            if (k < 4) begin
                check("d_add_idle", if_d.ad_d, 0);
                check("d_hsd_idle", if_d.hs_d, 0);
            end else begin
                off = (k - 4) % 1650;
                check("d_add", if_d.ad_d, (off < 1280) ? 1 : 0);
                check("d_hsd", if_d.hs_d, (off >= 1390 && off <= 1429) ? 1 : 0);
            end
            check("d_vsd", if_d.vs_d, 0);
            if (k < 1650 && if_d.ad === 1'b1) ad_cnt++;
        end
        check("d_ad_per_line", ad_cnt, 1280);
        rst_d = 1'b1;

        // Tiny raster: 8x6, HS/VS active low, same-cycle delayed copies, FPS 3
        rst_s = 1'b0;
        for (int k = 0; k < 4 * 48 + 6; k++) begin
            tick();
            hd  = k % 8;
            vv  = (k / 8) % 6;
            off = k % 48;
            fr  = k / 48;
            fce = (fr + ((off >= 28) ? 1 : 0)) % 3;
            check("s_h", if_s.hcount, hd);
            check("s_v", if_s.vcount, vv);
            check("s_ad", if_s.ad, (hd < 4 && vv < 3) ? 1 : 0);
            check("s_hs", if_s.hs, (hd == 5 || hd == 6) ? 0 : 1);
            check("s_vs", if_s.vs, (vv == 4) ? 0 : 1);
            check("s_nf", if_s.nf, (off == 28) ? 1 : 0);
            check("s_fc", if_s.fc, fce);
            check("s_add", if_s.ad_d, (hd < 4 && vv < 3) ? 1 : 0);
            check("s_hsd", if_s.hs_d, (hd == 5 || hd == 6) ? 0 : 1);
            check("s_vsd", if_s.vs_d, (vv == 4) ? 0 : 1);
        end
        rst_s = 1'b1;

        // 24x15 raster, FPS 20: run to frame 17, then reset mid-frame
        rst_m = 1'b0;
        for (int k = 0; k <= 6300; k++) begin
            tick();
            hd  = k % 24;
            vv  = (k / 24) % 15;
            off = k % 360;
            fr  = k / 360;
            fce = (fr + ((off >= 256) ? 1 : 0)) % 20;
            check("m_h", if_m.hcount, hd);
            check("m_v", if_m.vcount, vv);
            check("m_nf", if_m.nf, (off == 256) ? 1 : 0);
            check("m_fc", if_m.fc, fce);
            check("m_ad", if_m.ad, (hd < 16 && vv < 10) ? 1 : 0);
        end
        check("m_pre_h",  if_m.hcount, 12);
        check("m_pre_v",  if_m.vcount, 7);
        check("m_pre_fc", if_m.fc, 17);
        check("m_pre_add", if_m.ad_d, 1);

        rst_m = 1'b1;
        tick();
        check("m_mid_h",  if_m.hcount, 0);
        check("m_mid_v",  if_m.vcount, 0);
        check("m_mid_fc", if_m.fc, 0);
        check("m_mid_nf", if_m.nf, 0);
        check("m_mid_ad", if_m.ad, 0);
        check("m_mid_add", if_m.ad_d, 0);
        check("m_mid_hsd", if_m.hs_d, 0);
        check("m_mid_vsd", if_m.vs_d, 0);
        rst_m = 1'b0;
        for (int j = 0; j < 6; j++) begin
            tick();
            check("m_rel_h",  if_m.hcount, j);
            check("m_rel_v",  if_m.vcount, 0);
            check("m_rel_fc", if_m.fc, 0);
            check("m_rel_ad", if_m.ad, 1);
            check("m_rel_add", if_m.ad_d, (j >= 3) ? 1 : 0);
            check("m_rel_hsd", if_m.hs_d, 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
